// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer
//   Owns the fetch program counter and sequences control-flow changes.
//   A resolved branch or jump from execute redirects the PC to the target
//   and raises flush for FLUSH_CYCLES cycles so the wrong-path instructions
//   already in IF/ID and ID/EX are killed. Stall holds the PC, halt freezes
//   the core until reset, and a saturating counter tallies accepted redirects.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC this cycle (RUN only)
//   branch_enable  conditional branch resolved taken
//   jump           unconditional JAL/JALR redirect
//   target         redirect destination (bit 0 forced to 0 on load)
//   halt           ECALL/EBREAK retire: freeze the core
//   pc             current fetch address (registered)
//   pc_plus4       pc + 4, combinational, wraps modulo 2^XLEN
//   flush          kill wrong-path pipeline contents (registered state)
//   misaligned     sticky: an accepted redirect had target[1]=1
//   halted         high while in HALTED
//   taken_count    accepted redirects, saturating
module pc_branch_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_enable,
  input  logic             jump,
  input  logic [XLEN-1:0]  target,
  input  logic             halt,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             flush,
  output logic             misaligned,
  output logic             halted,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic             mis_q, mis_d;
  logic             redirect;

  assign redirect = branch_enable | jump;
  assign pc_plus4 = pc_q + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      fcnt_q  <= '0;
      taken_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_RUN: begin
        // halt beats redirect, redirect beats stall
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          pc_d    = {target[XLEN-1:1], 1'b0};
          state_d = S_FLUSH;
          // Counter holds the number of flush cycles still to come after
          // the first one, so the pulse is exactly FLUSH_CYCLES wide.
          fcnt_d  = 3'(FLUSH_CYCLES - 1);
          if (!(&taken_q)) taken_d = taken_q + CNT_W'(1);
          if (target[1]) mis_d = 1'b1;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      S_FLUSH: begin
        // Redirect requests here come from wrong-path instructions and
        // stall is meaningless while the pipe is being killed.
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          pc_d = pc_plus4;
          if (fcnt_q == 3'd0) state_d = S_RUN;
          else                fcnt_d  = fcnt_q - 3'd1;
        end
      end
      S_HALTED: begin
        // frozen until reset
      end
      default: state_d = S_RUN;
    endcase
  end

  assign pc          = pc_q;
  assign flush       = (state_q == S_FLUSH);
  assign halted      = (state_q == S_HALTED);
  assign misaligned  = mis_q;
  assign taken_count = taken_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;
    localparam int XLEN  = 32;
    localparam int FC    = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall, branch_enable, jump, halt;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  pc, pc_plus4;
    logic             flush, misaligned, halted;
    logic [CNT_W-1:0] taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    int          m_flush_rem;
    bit          m_halted, m_mis;
    int          m_cnt;

    pc_branch_sequencer #(
        .XLEN(XLEN), .RESET_PC(32'h0), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_enable(branch_enable),
        .jump(jump), .target(target), .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
        .flush(flush), .misaligned(misaligned), .halted(halted),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 32'h0; m_flush_rem = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge(bit s, bit b, bit j, bit h, logic [31:0] t);
        if (m_halted) return;
        if (m_flush_rem > 0) begin
            if (h) begin m_halted = 1; m_flush_rem = 0; end
            else begin m_pc = m_pc + 32'd4; m_flush_rem--; end
        end else if (h) begin
            m_halted = 1;
        end else if (b || j) begin
            m_pc = t & ~32'd1;
            m_flush_rem = FC;
            if (m_cnt < CMAX) m_cnt++;
            if (t[1]) m_mis = 1;
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic cycle(input bit s, input bit b, input bit j, input bit h,
                         input logic [31:0] t);
        stall = s; branch_enable = b; jump = j; halt = h; target = t;
        @(posedge clk);
        model_edge(s, b, j, h, t);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stall = 0; branch_enable = 0; jump = 0; halt = 0; target = '0;
        do_reset();
        n_checks++;
        if (pc !== 32'h0 || flush !== 1'b0 || halted !== 1'b0 ||
            misaligned !== 1'b0 || taken_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h flush=%b halted=%b mis=%b cnt=%0d, required pc=0 others 0",
                     pc, flush, halted, misaligned, taken_count);
        end
        release_reset();
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 32'h0);
            n_checks++;
            if (pc !== 32'(4 * k) || flush !== 1'b0 || pc_plus4 !== 32'(4 * k + 4)) begin
                n_fail++;
                $display("FAIL seq_pc[%0d]: pc=%h pc_plus4=%h flush=%b, required pc=%h pc_plus4=%h flush=0",
                         k, pc, pc_plus4, flush, 32'(4 * k), 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [3];
        int flush_cycles;
        exp_pc[0] = 32'h40; exp_pc[1] = 32'h44; exp_pc[2] = 32'h48;
        cycle(0, 0, 0, 0, 32'h0);
        n_checks++;
        if (pc !== 32'h10) begin
            n_fail++;
            $display("FAIL branch_pre_pc: pc=%h, required 00000010", pc);
        end
        flush_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) cycle(0, 1, 0, 0, 32'h40);
            else        cycle(0, 0, 0, 0, 32'h0);
            if (flush) flush_cycles++;
            n_checks++;
            if (pc !== exp_pc[k] || flush !== (m_flush_rem > 0)) begin
                n_fail++;
                $display("FAIL branch_pc[%0d]: pc=%h flush=%b, required pc=%h flush=%b",
                         k, pc, flush, exp_pc[k], (m_flush_rem > 0));
            end
        end
        n_checks++;
        if (flush_cycles != FC || taken_count !== 4'd1) begin
            n_fail++;
            $display("FAIL branch_flush_width: flush_cycles=%0d cnt=%0d, required %0d and 1",
                     flush_cycles, taken_count, FC);
        end
    endtask

    task automatic test_redirect_in_flush();
        cycle(0, 1, 0, 0, 32'h200);
        cycle(0, 0, 1, 0, 32'h80);
        n_checks++;
        if (pc !== 32'h204 || taken_count !== 4'(m_cnt) || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ignores_jump: pc=%h cnt=%0d flush=%b, required pc=00000204 cnt=%0d flush=1",
                     pc, taken_count, flush, m_cnt);
        end
        cycle(0, 0, 0, 0, 32'h0);
        n_checks++;
        if (pc !== 32'h208 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: pc=%h flush=%b, required pc=00000208 flush=0", pc, flush);
        end
    endtask

    task automatic test_stall();
        cycle(1, 1, 0, 0, 32'h100);
        n_checks++;
        if (pc !== 32'h100 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_vs_branch: pc=%h flush=%b, required pc=00000100 flush=1", pc, flush);
        end
        while (m_flush_rem > 0) cycle(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 32'h0);
            n_checks++;
            if (pc !== m_pc || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h flush=%b, required pc=%h flush=0", k, pc, flush, m_pc);
            end
        end
    endtask

    task automatic test_misaligned();
        cycle(0, 0, 1, 0, 32'h22);
        n_checks++;
        if (pc !== 32'h22 || misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_set: pc=%h mis=%b, required pc=00000022 mis=1", pc, misaligned);
        end
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 32'h0);
        n_checks++;
        if (misaligned !== 1'b1 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL misaligned_sticky: mis=%b pc=%h, required mis=1 pc=%h", misaligned, pc, m_pc);
        end
        do_reset();
        n_checks++;
        if (misaligned !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_reset: mis=%b pc=%h, required mis=0 pc=0", misaligned, pc);
        end
        release_reset();
        cycle(0, 0, 1, 0, 32'h21);
        n_checks++;
        if (pc !== 32'h20 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL bit0_clear: pc=%h mis=%b, required pc=00000020 mis=0", pc, misaligned);
        end
    endtask

    task automatic test_wrap();
        while (m_flush_rem > 0) cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'hFFFF_FFF8);
        cycle(0, 0, 0, 0, 32'h0);
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_plus4: pc=%h pc_plus4=%h, required fffffffc and 00000000", pc, pc_plus4);
        end
        cycle(0, 0, 0, 0, 32'h0);
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h, required 00000000", pc);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 1, 0, 32'h1000 + 32'(16 * k));
            while (m_flush_rem > 0) cycle(0, 0, 0, 0, 32'h0);
        end
        n_checks++;
        if (taken_count !== 4'(CMAX) || 4'(m_cnt) !== 4'(CMAX)) begin
            n_fail++;
            $display("FAIL count_saturate: cnt=%0d, required %0d", taken_count, CMAX);
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        frozen = m_pc;
        cycle(0, 0, 0, 1, 32'h0);
        n_checks++;
        if (halted !== 1'b1 || pc !== frozen) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b pc=%h, required halted=1 pc=%h", halted, pc, frozen);
        end
        for (int k = 0; k < 20; k++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            n_checks++;
            if (pc !== frozen || halted !== 1'b1 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: pc=%h halted=%b flush=%b, required pc=%h halted=1 flush=0",
                         k, pc, halted, flush, frozen);
            end
        end
        do_reset();
        release_reset();
        cycle(0, 1, 0, 0, 32'h300);
        n_checks++;
        if (flush !== 1'b1 || pc !== 32'h300) begin
            n_fail++;
            $display("FAIL pre_async_reset: flush=%b pc=%h, required flush=1 pc=00000300", flush, pc);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (pc !== 32'h0 || flush !== 1'b0 || taken_count !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mid_flush: pc=%h flush=%b cnt=%0d, required pc=0 flush=0 cnt=0",
                     pc, flush, taken_count);
        end
        release_reset();
    endtask

    task automatic test_random();
        int halted_for;
        bit s, b, j, h;
        logic [31:0] t;
        halted_for = 0;
        for (int k = 0; k < 1500; k++) begin
            s = ($urandom_range(3) == 0);
            b = ($urandom_range(7) == 0);
            j = ($urandom_range(9) == 0);
            h = ($urandom_range(150) == 0);
            t = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            cycle(s, b, j, h, t);
            n_checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || flush !== (m_flush_rem > 0)) begin
                n_fail++;
                $display("FAIL rand_pc[%0d]: pc=%h pc_plus4=%h flush=%b, required pc=%h pc_plus4=%h flush=%b",
                         k, pc, pc_plus4, flush, m_pc, m_pc + 32'd4, (m_flush_rem > 0));
            end
            n_checks++;
            if (halted !== m_halted || misaligned !== m_mis || taken_count !== 4'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: halted=%b mis=%b cnt=%0d, required halted=%b mis=%b cnt=%0d",
                         k, halted, misaligned, taken_count, m_halted, m_mis, m_cnt);
            end
            if (m_halted) halted_for++;
            if (halted_for > 4) begin
                halted_for = 0;
                do_reset();
                release_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_redirect_in_flush();
        test_stall();
        test_misaligned();
        test_wrap();
        test_saturation();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
